stream_accumulator_4bit: RTL and testbench



---
 rtl/stream_accumulator_4bit_pkg.sv | 12 +
 rtl/stream_accumulator_4bit_adder.sv | 26 ++
 rtl/stream_accumulator_4bit.sv | 110 +++++++++++
 tb/tb_stream_accumulator_4bit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/stream_accumulator_4bit_pkg.sv
// Shared constants for the stream accumulator: FSM state encoding and
// default datapath widths.
package stream_accumulator_4bit_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int LEN_W_DEF = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/stream_accumulator_4bit_adder.sv
// Purely combinational ripple-carry adder, one full-adder cell per bit with
// the carry chained from the LSB upward.
module adder_4bit_rca #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   logic [WIDTH:0] carry;

   assign carry[0] = cin;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa_cell
      logic half_sum;
      assign half_sum      = a[gi] ^ b[gi];
      assign s[gi]         = half_sum ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & half_sum);
   end

   assign cout = carry[WIDTH];

endmodule

// File: rtl/stream_accumulator_4bit.sv
// Burst accumulator: accepts len operands over valid/ready, sums them modulo
// 2^WIDTH with a sticky carry flag, and offers the result on a valid/ready port.
module stream_accumulator_4bit
   import stream_accumulator_4bit_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             start_in,
   input  logic [LEN_W-1:0] len_in,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid_in,
   output logic             data_ready_out,
   output logic [WIDTH-1:0] sum_out,
   output logic             ovf_out,
   output logic             sum_valid_out,
   input  logic             sum_ready_in,
   output logic             busy_out,
   output logic [LEN_W-1:0] count_out
);

   logic [1:0]       state_reg, state_next;
   logic [WIDTH-1:0] acc_reg, acc_next;
   logic             ovf_reg, ovf_next;
   logic [LEN_W-1:0] count_reg, count_next;
   logic [LEN_W-1:0] len_reg, len_next;

   logic [WIDTH-1:0] add_sum;
   logic             add_cout;
   logic [LEN_W-1:0] count_inc;
   logic             accept;

   adder_4bit_rca #(
      .WIDTH (WIDTH)
   ) u_adder (
      .a    (acc_reg),
      .b    (data_in),
      .cin  (1'b0),
      .s    (add_sum),
      .cout (add_cout)
   );

   assign count_inc = count_reg + LEN_W'(1);
   assign accept    = (state_reg == ST_ACCUM) && data_valid_in;

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      ovf_next   = ovf_reg;
      count_next = count_reg;
      len_next   = len_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start_in) begin
               len_next   = len_in;
               acc_next   = '0;
               ovf_next   = 1'b0;
               count_next = '0;
               state_next = (len_in == '0) ? ST_DONE : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (accept) begin
               acc_next   = add_sum;
               ovf_next   = ovf_reg | add_cout;
               count_next = count_inc;
               // Leaving ACCUM here drops ready next cycle, so len is a hard cap.
               if (count_inc == len_reg) begin
                  state_next = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (sum_ready_in) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_reg <= ST_IDLE;
         acc_reg   <= '0;
         ovf_reg   <= 1'b0;
         count_reg <= '0;
         len_reg   <= '0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         ovf_reg   <= ovf_next;
         count_reg <= count_next;
         len_reg   <= len_next;
      end
   end

   // Every output is decoded from registers only.
   assign data_ready_out = (state_reg == ST_ACCUM);
   assign sum_valid_out  = (state_reg == ST_DONE);
   assign busy_out       = (state_reg != ST_IDLE);
   assign sum_out        = acc_reg;
   assign ovf_out        = ovf_reg;
   assign count_out      = count_reg;

endmodule

// File: tb/tb_stream_accumulator_4bit.sv
// Randomized bench for stream_accumulator_4bit; expected results come from
// plain arithmetic over each burst's operand list.
module tb_stream_accumulator_4bit;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic       start_in = 1'b0;
   logic [3:0] len_in = '0;
   logic [3:0] data_in = '0;
   logic       data_valid_in = 1'b0;
   logic       data_ready_out;
   logic [3:0] sum_out;
   logic       ovf_out;
   logic       sum_valid_out;
   logic       sum_ready_in = 1'b0;
   logic       busy_out;
   logic [3:0] count_out;

   int n_checks = 0;
   int n_fail   = 0;
   logic [3:0] burst_ops [16];

   stream_accumulator_4bit #(
      .WIDTH (4),
      .LEN_W (4)
   ) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .start_in       (start_in),
      .len_in         (len_in),
      .data_in        (data_in),
      .data_valid_in  (data_valid_in),
      .data_ready_out (data_ready_out),
      .sum_out        (sum_out),
      .ovf_out        (ovf_out),
      .sum_valid_out  (sum_valid_out),
      .sum_ready_in   (sum_ready_in),
      .busy_out       (busy_out),
      .count_out      (count_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_sum"},   sum_out, 0);
      check_val({tag, "_ovf"},   ovf_out, 0);
      check_val({tag, "_valid"}, sum_valid_out, 0);
      check_val({tag, "_ready"}, data_ready_out, 0);
      check_val({tag, "_busy"},  busy_out, 0);
      check_val({tag, "_count"}, count_out, 0);
   endtask

   // mode: 0 continuous valid, 1 valid every other cycle, 2 random valid.
   // hold: cycles of backpressure in DONE. poke: drive stray starts while busy.
   task automatic run_burst(input int len, input int mode, input int hold, input bit poke);
      int total = 0;
      int accepted = 0;
      int cyc = 0;
      bit v;
      int sum_e;
      int ovf_e;
      for (int k = 0; k < len; k++) total += int'(burst_ops[k]);
      sum_e = total % 16;
      ovf_e = (total >= 16) ? 1 : 0;

      check_val("idle_busy", busy_out, 0);
      start_in      = 1'b1;
      len_in        = 4'(len);
      data_valid_in = (len == 0);
      data_in       = 4'hF;
      @(negedge clk_in);
      start_in = 1'b0;
      check_val("start_busy", busy_out, 1);
      check_val("start_count", count_out, 0);
      if (len == 0) begin
         check_val("len0_ready", data_ready_out, 0);
         check_val("len0_valid", sum_valid_out, 1);
         check_val("len0_sum", sum_out, 0);
         check_val("len0_ovf", ovf_out, 0);
      end else begin
         check_val("start_ready", data_ready_out, 1);
         check_val("start_valid", sum_valid_out, 0);
      end

      while (accepted < len && cyc < 200) begin
         if (mode == 0) v = 1'b1;
         else if (mode == 1) v = (cyc % 2 == 0);
         else v = 1'($urandom_range(0, 1));
         data_valid_in = v;
         data_in = v ? burst_ops[accepted] : 4'($urandom);
         if (poke) begin
            start_in = 1'($urandom_range(0, 1));
            len_in   = 4'($urandom);
         end
         @(negedge clk_in);
         cyc++;
         if (v) accepted++;
         check_val("count", count_out, accepted);
         if (accepted < len) begin
            check_val("accum_ready", data_ready_out, 1);
            check_val("accum_valid", sum_valid_out, 0);
         end else begin
            check_val("latency_valid", sum_valid_out, 1);
            check_val("done_ready", data_ready_out, 0);
         end
      end
      if (accepted < len) check_val("accept_timeout", accepted, len);

      // Extra operand offered while the result waits; it must not be taken.
      data_valid_in = 1'b1;
      data_in       = 4'($urandom_range(1, 15));
      for (int h = 0; h < hold; h++) begin
         sum_ready_in = 1'b0;
         start_in     = poke;
         @(negedge clk_in);
         check_val("hold_valid", sum_valid_out, 1);
         check_val("hold_sum", sum_out, sum_e);
         check_val("hold_ovf", ovf_out, ovf_e);
         check_val("hold_count", count_out, len);
         check_val("hold_ready", data_ready_out, 0);
      end
      sum_ready_in = 1'b1;
      start_in     = poke;
      @(negedge clk_in);
      check_val("post_valid", sum_valid_out, 0);
      check_val("post_busy", busy_out, 0);
      check_val("post_sum", sum_out, sum_e);
      check_val("post_ovf", ovf_out, ovf_e);
      sum_ready_in  = 1'b0;
      start_in      = 1'b0;
      data_valid_in = 1'b0;
      $display("burst len=%0d mode=%0d hold=%0d poke=%0d -> sum=%0d ovf=%0d (exp %0d/%0d)",
               len, mode, hold, poke, sum_out, ovf_out, sum_e, ovf_e);
   endtask

   initial begin
      repeat (2) @(negedge clk_in);
      check_all_zero("reset");
      rst_in = 1'b0;
      @(negedge clk_in);

      burst_ops[0] = 4'd3; burst_ops[1] = 4'd5; burst_ops[2] = 4'd7;
      run_burst(3, 0, 0, 1'b0);

      burst_ops[0] = 4'd9; burst_ops[1] = 4'd9;
      run_burst(2, 0, 1, 1'b0);
      burst_ops[0] = 4'd4;
      run_burst(1, 0, 0, 1'b0);

      run_burst(0, 0, 2, 1'b0);

      for (int k = 0; k < 4; k++) burst_ops[k] = 4'd1;
      run_burst(4, 1, 5, 1'b0);

      // Asynchronous reset after two of five operands.
      start_in = 1'b1;
      len_in   = 4'd5;
      @(negedge clk_in);
      start_in      = 1'b0;
      data_valid_in = 1'b1;
      data_in       = 4'd7;
      repeat (2) @(negedge clk_in);
      check_val("pre_rst_count", count_out, 2);
      #2 rst_in = 1'b1;
      #1 check_all_zero("async_rst");
      data_valid_in = 1'b0;
      @(negedge clk_in);
      rst_in = 1'b0;
      @(negedge clk_in);
      burst_ops[0] = 4'd6;
      run_burst(1, 0, 0, 1'b0);

      for (int k = 0; k < 4; k++) burst_ops[k] = 4'(k + 2);
      run_burst(4, 0, 3, 1'b1);

      for (int b = 0; b < 25; b++) begin
         int len_r;
         len_r = $urandom_range(0, 15);
         for (int k = 0; k < 16; k++) burst_ops[k] = 4'($urandom);
         run_burst(len_r, $urandom_range(0, 2), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) @(negedge clk_in);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
